// File: rtl/se_sram_srw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : se_sram_srw_arbiter
// Description : Two-port arbiter in front of a single-port synchronous SRAM.
//               It registers one granted access per cycle into the SRAM
//               command stage. A 2-deep tag pipeline returns each read word
//               to the port that issued it.
//               Defining SE_SRAM_ARB_ROUND_ROBIN_EN makes contention
//               round-robin. Without it, port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module se_sram_srw_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     sram_clock,
    input  logic                     reset,

    input  logic                     p0_req,
    input  logic                     p0_read_not_write,
    input  logic [ADDRESS_WIDTH-1:0] p0_address,
    input  logic [DATA_WIDTH-1:0]    p0_write_data,
    output logic                     p0_ack,
    output logic                     p0_resp_valid,
    output logic [DATA_WIDTH-1:0]    p0_resp_data,

    input  logic                     p1_req,
    input  logic                     p1_read_not_write,
    input  logic [ADDRESS_WIDTH-1:0] p1_address,
    input  logic [DATA_WIDTH-1:0]    p1_write_data,
    output logic                     p1_ack,
    output logic                     p1_resp_valid,
    output logic [DATA_WIDTH-1:0]    p1_resp_data,

    output logic                     sram_select,
    output logic                     sram_read_not_write,
    output logic                     sram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0]    sram_write_data,
    input  logic [DATA_WIDTH-1:0]    sram_data_out
);

    logic                     w_p1_priority;
    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_any_grant;
    logic                     w_sel_rnw;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;

    logic                     r_select;
    logic                     r_rnw;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;

    logic                     r_tag1_valid;
    logic                     r_tag1_port;
    logic                     r_tag2_valid;
    logic                     r_tag2_port;

    logic                     w_resp0;
    logic                     w_resp1;
    logic [DATA_WIDTH-1:0]    r_p0_data;
    logic [DATA_WIDTH-1:0]    r_p1_data;

`ifdef SE_SRAM_ARB_ROUND_ROBIN_EN
    logic w_contend;
    logic r_rr_p1_next;

    assign w_contend = p0_req & p1_req;

    // Set when port 0 won the last contention, so port 1 wins the next one.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            r_rr_p1_next <= 1'b0;
        end else if (w_contend) begin
            r_rr_p1_next <= w_grant0;
        end
    end

    assign w_p1_priority = r_rr_p1_next;
`else
    assign w_p1_priority = 1'b0;
`endif

    assign w_grant0    = !reset & p0_req & (!p1_req | !w_p1_priority);
    assign w_grant1    = !reset & p1_req & (!p0_req |  w_p1_priority);
    assign w_any_grant = w_grant0 | w_grant1;

    assign w_sel_rnw   = w_grant1 ? p1_read_not_write : p0_read_not_write;
    assign w_sel_addr  = w_grant1 ? p1_address        : p0_address;
    assign w_sel_wdata = w_grant1 ? p1_write_data     : p0_write_data;

    assign p0_ack = w_grant0;
    assign p1_ack = w_grant1;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            r_select     <= 1'b0;
            r_rnw        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_tag1_valid <= 1'b0;
            r_tag1_port  <= 1'b0;
            r_tag2_valid <= 1'b0;
            r_tag2_port  <= 1'b0;
        end else begin
            r_tag1_valid <= w_any_grant & w_sel_rnw;
            r_tag1_port  <= w_grant1;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_port  <= r_tag1_port;
            if (w_any_grant) begin
                r_select <= 1'b1;
                r_rnw    <= w_sel_rnw;
                r_we     <= !w_sel_rnw;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
            end else begin
                // Idle cycle: address and data hold to avoid needless toggling.
                r_select <= 1'b0;
                r_we     <= 1'b0;
            end
        end
    end

    assign sram_select         = r_select;
    assign sram_read_not_write = r_rnw;
    assign sram_write_enable   = r_we;
    assign sram_address        = r_addr;
    assign sram_write_data     = r_wdata;

    assign w_resp0 = !reset & r_tag2_valid & !r_tag2_port;
    assign w_resp1 = !reset & r_tag2_valid &  r_tag2_port;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            r_p0_data <= '0;
            r_p1_data <= '0;
        end else begin
            if (w_resp0) begin
                r_p0_data <= sram_data_out;
            end
            if (w_resp1) begin
                r_p1_data <= sram_data_out;
            end
        end
    end

    // Bypass so the read word is visible in the same cycle as resp_valid.
    assign p0_resp_valid = w_resp0;
    assign p1_resp_valid = w_resp1;
    assign p0_resp_data  = w_resp0 ? sram_data_out : r_p0_data;
    assign p1_resp_data  = w_resp1 ? sram_data_out : r_p1_data;

endmodule
`default_nettype wire

// File: doc/se_sram_srw_arbiter.md
Name: se_sram_srw_arbiter

Overview:
- Two-requester arbiter sitting directly upstream of a single-port synchronous SRAM; drives its `select`, `read_not_write`, `write_enable`, `address` and `write_data` inputs and consumes its registered `data_out`.
- Accepts one access per cycle from either requester and registers it into the SRAM command stage.
- Tracks outstanding reads by port and returns each read word to the requester that issued it.
- Used wherever two masters (e.g. CPU fetch and debug/DMA) share one SRAM instance.

Parameters:
- `address_width`, 16, SRAM address bits
- `data_width`, 32, SRAM word width

Ports:
- `sram_clock`  in  1  single clock, shared with the SRAM
- `reset`  in  1  synchronous, active-high reset
- `p0_req`  in  1  port 0 access request, held until acked
- `p0_read_not_write`  in  1  1 = read, 0 = write
- `p0_address`  in  `address_width`  port 0 address
- `p0_write_data`  in  `data_width`  port 0 write data
- `p0_ack`  out  1  port 0 request accepted this cycle
- `p0_resp_valid`  out  1  port 0 read data valid this cycle
- `p0_resp_data`  out  `data_width`  port 0 read data, held until next port 0 response
- `p1_req`, `p1_read_not_write`, `p1_address`, `p1_write_data`, `p1_ack`, `p1_resp_valid`, `p1_resp_data`: as port 0, for port 1
- `sram_select`  out  1  to SRAM `select`
- `sram_read_not_write`  out  1  to SRAM `read_not_write`
- `sram_write_enable`  out  1  to SRAM `write_enable`
- `sram_address`  out  `address_width`  to SRAM `address`
- `sram_write_data`  out  `data_width`  to SRAM `write_data`
- `sram_data_out`  in  `data_width`  from SRAM `data_out`

Behaviour:
- **Reset values.** When `reset` is sampled high:
  - All `sram_*` outputs are 0.
  - All `resp_valid` outputs are 0; `resp_data` registers are 0.
  - The read tag pipeline is cleared.
  - The round-robin pointer selects port 0.
  - `p0_ack`/`p1_ack` are 0 during reset.
- **Arbitration (cycle N).**
  - `pX_ack` is combinational from `req` and the grant; at most one ack per cycle.
  - Only one requesting port: that port is acked.
  - Both requesting: the grant follows the priority rule (see Optional Feature).
  - No stall exists: any request is acked in its first cycle unless the other port wins.
- **Command stage.**
  - On the edge ending cycle N, the granted request is registered into the `sram_*` outputs: `sram_select=1`, `sram_read_not_write` = port rnw, `sram_write_enable` = !rnw.
  - If no ack in cycle N, `sram_select=0` and `sram_write_enable=0` in N+1; address/data hold their previous value.
- **SRAM behaviour.** The SRAM samples the command at the end of N+1. A read's data appears on `sram_data_out` during N+2.
- **Read return.**
  - A 2-deep tag pipeline (valid, port) follows each read.
  - In N+2, the tagged port's `resp_valid`=1 for exactly one cycle and its `resp_data` register loads `sram_data_out`, visible from N+2 (bypass mux).
  - `resp_data` is held until that port's next read response.
  - Writes produce no response.
- **Latency and throughput.** Read latency is 2 cycles from ack to `resp_valid`. Throughput is one access per cycle, back-to-back, in any read/write mix.
- **Read-after-write ordering.** Commands reach the SRAM in grant order. A read acked the cycle after a write to the same address returns the new data.
- **Simultaneous read responses.** Impossible; only one command issues per cycle.
- **Address wrap.** None; the address passes unchanged.
- **Reset mid-operation.** Outstanding read tags are discarded, so no `resp_valid` appears after reset. SRAM contents are untouched.

Optional Feature:
- Macro: `SE_SRAM_ARB_ROUND_ROBIN_EN`.
- **Defined:**
  - On contention, the grant goes to the port not granted at the last contended cycle.
  - The pointer updates only on cycles where both `req` are high.
  - After reset, port 0 wins the first contention.
- **Undefined:**
  - Fixed priority: port 0 always wins contention, and port 1 can starve.
  - The pointer register is not built.

Test Plan:
- **Idle after reset.** Reset 2 cycles, no reqs -> all `sram_*`=0, acks=0, `resp_valid`=0, `resp_data`=0.
- **Port 0 write then read.** Port 0 write addr 0x0010 data 0xDEADBEEF in cycle 5, read 0x0010 in cycle 6 -> `sram_select`=1/`write_enable`=1 in cycle 6; `p0_resp_valid`=1 with 0xDEADBEEF in cycle 8.
- **Contention, round-robin build.** Both ports request reads of 0x0001 (p0) and 0x0002 (p1), held high 4 cycles -> acks alternate p0,p1,p0,p1; responses alternate p0,p1 two cycles later. Fixed-priority build -> p0 acked every cycle, p1 never.
- **Interleaved writes.** p1 writes 0x55 to 0x0003 while p0 reads 0x0003 the next cycle -> `p0_resp_data`=0x55; `p1_resp_valid` stays 0.
- **Reset with reads in flight.** Reset asserted the cycle after a p1 read ack -> no `p1_resp_valid` ever; `p1_resp_data`=0.
- **Back-to-back mixed stream.** p0 issues read/write/read at 0x7FFF, 0x0000, 0xFFFF -> `sram_address` follows one cycle after each ack; exactly 2 `p0_resp_valid` pulses.
